// File: rtl/pc_ctrl.sv
// Fetch PC controller: issues instruction-memory requests, holds the fetched word for the
// decoder and handles redirect/halt. Define PC_CTRL_MISALIGN_TRAP_EN to trap misaligned redirects.
module pc_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        halt_i,
   output logic        misalign_o
);

`ifdef PC_CTRL_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic        kill_q, kill_d;
   logic        misalign_q, misalign_d;

   logic        tgt_misaligned;
   logic [31:0] tgt_pc;

   // Misaligned targets trap only when the feature is built in; otherwise low bits are dropped.
   always_comb begin
      tgt_misaligned = |redirect_pc_i[1:0];
      if (TrapEn && tgt_misaligned) begin
         tgt_pc = TRAP_VEC;
      end else begin
         tgt_pc = {redirect_pc_i[31:2], 2'b00};
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      kill_d     = kill_q;
      misalign_d = 1'b0;

      if (redirect_i) begin
         misalign_d = TrapEn && tgt_misaligned;
      end

      unique case (state_q)
         StIdle: begin
            if (redirect_i) begin
               pc_d    = tgt_pc;
               state_d = StReq;
            end else if (halt_i) begin
               state_d = StHalt;
            end else begin
               state_d = StReq;
            end
         end

         StReq: begin
            if (redirect_i) begin
               pc_d = tgt_pc;
               // A grant taken alongside a redirect is still outstanding: drain it, then refetch.
               if (imem_gnt_i) begin
                  kill_d  = 1'b1;
                  state_d = StWait;
               end else begin
                  state_d = StReq;
               end
            end else if (imem_gnt_i) begin
               state_d = StWait;
            end
         end

         StWait: begin
            if (redirect_i) begin
               pc_d = tgt_pc;
               if (imem_rvalid_i) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  instr_d    = imem_rdata_i;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  state_d    = StHold;
               end
            end
         end

         StHold: begin
            if (redirect_i) begin
               valid_d = 1'b0;
               pc_d    = tgt_pc;
               state_d = StReq;
            end else if (!stall_i) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 32'd4;
               state_d = halt_i ? StHalt : StReq;
            end
         end

         StHalt: begin
            if (redirect_i) begin
               pc_d    = tgt_pc;
               state_d = StReq;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pc_q       <= RESET_VEC;
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
         valid_q    <= 1'b0;
         kill_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         kill_q     <= kill_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o          = pc_q;
   assign imem_req_o    = (state_q == StReq);
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign misalign_o    = misalign_q;

endmodule
